// File: rtl/inst_mem_loader.sv
// Byte-stream loader for the instruction store, with a combinational big-endian
// word-read port for the fetch stage. Holds the processor until a load completes.
module inst_mem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [29:0]       rd_pc,
    output logic [31:0]       rd_inst,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PAD  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W:0]   addr;
    logic [ADDR_W:0]   addr_nxt;
    logic [7:0]        mem [DEPTH];
    logic              accept;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [ADDR_W-3:0] pc;

    // Handshake and write-port decode; ld_start always wins over a pending write.
    always_comb begin
        ld_ready = (state == S_LOAD) && (addr < FULL);
        accept   = ld_ready && ld_valid && !ld_start;
        addr_nxt = addr + ONE;
        if (accept) begin
            wr_en   = 1'b1;
            wr_data = ld_byte;
        end else if ((state == S_PAD) && !ld_start) begin
            wr_en   = 1'b1;
            wr_data = 8'h00;
        end else begin
            wr_en   = 1'b0;
            wr_data = 8'h00;
        end
    end

    // Loader state machine; done/cpu_hold follow the DONE state one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            byte_count <= '0;
            checksum   <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else if (ld_start) begin
            state      <= S_LOAD;
            addr       <= '0;
            byte_count <= '0;
            checksum   <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            done     <= (state == S_DONE);
            cpu_hold <= (state != S_DONE);
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        addr       <= addr_nxt;
                        byte_count <= byte_count + ONE;
                        checksum   <= checksum + ld_byte;
                        if (ld_last) begin
                            state <= (addr_nxt[1:0] == 2'b00) ? S_DONE : S_PAD;
                        end
                    end else if (ld_valid && (addr == FULL)) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end
                end
                S_PAD: begin
                    addr       <= addr_nxt;
                    byte_count <= byte_count + ONE;
                    if (addr_nxt[1:0] == 2'b00) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Store array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Big-endian word read; upper pc bits are dropped so addresses wrap.
    always_comb begin
        pc      = rd_pc[ADDR_W-3:0];
        rd_inst = {mem[{pc, 2'b00}], mem[{pc, 2'b01}], mem[{pc, 2'b10}], mem[{pc, 2'b11}]};
    end

endmodule
